// File: rtl/mem_responder_model.sv
// Fixed-latency responder for the req/resp memory interface: small backing store,
// init delay, outstanding-read limit and periodic refresh stalls.
module mem_responder_model #(
  parameter int unsigned DEPTH            = 256,
  parameter int unsigned LINE_BYTES       = 64,
  parameter int unsigned READ_LATENCY     = 8,
  parameter int unsigned MAX_OUTSTANDING  = 4,
  parameter int unsigned INIT_CYCLES      = 16,
  parameter int unsigned REFRESH_INTERVAL = 200,
  parameter int unsigned REFRESH_CYCLES   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic        req_type,
  input  logic [31:0] req_source_id,
  input  logic [63:0] req_data,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_addr,
  output logic [63:0] resp_data,
  output logic        init_done
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned INIT_W = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam int unsigned RI_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int unsigned RC_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_READY, ST_REFRESH} state_e;

  state_e                  state_q;
  logic [INIT_W-1:0]       init_cnt_q;
  logic [RI_W-1:0]         ref_tmr_q;
  logic [RC_W-1:0]         ref_cnt_q;
  logic [OUT_W-1:0]        outstanding_q;
  logic [OUT_W-1:0]        outstanding_d;
  logic                    req_ready_q;
  logic                    init_done_q;
  logic                    resp_valid_q;
  logic [63:0]             resp_addr_q;
  logic [63:0]             resp_data_q;

  logic [63:0]             mem_q     [DEPTH];
  logic [DEPTH-1:0]        written_q;
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [63:0]             pipe_addr_q [READ_LATENCY];
  logic [63:0]             pipe_data_q [READ_LATENCY];

  logic [IDX_W-1:0]        req_idx_c;
  logic                    acc_c;
  logic                    acc_rd_c;
  logic                    acc_wr_c;
  logic                    launch_c;
  logic                    ready_next_c;
  logic [63:0]             rd_data_c;
  logic                    unused_c;

  assign req_idx_c     = req_addr[OFF_W +: IDX_W];
  assign acc_c         = req_valid & req_ready_q;
  assign acc_rd_c      = acc_c & ~req_type;
  assign acc_wr_c      = acc_c & req_type;
  assign launch_c      = pipe_vld_q[READ_LATENCY-1];
  assign rd_data_c     = written_q[req_idx_c] ? mem_q[req_idx_c] : req_addr;
  assign outstanding_d = outstanding_q + OUT_W'(acc_rd_c) - OUT_W'(launch_c);
  assign ready_next_c  = (outstanding_d < OUT_W'(MAX_OUTSTANDING));
  assign unused_c      = ^req_source_id;

  // Backing store contents survive reset; only the written flags are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && acc_wr_c) begin
      mem_q[req_idx_c] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      written_q <= '0;
    end else if (acc_wr_c) begin
      written_q[req_idx_c] <= 1'b1;
    end
  end

  // Read payload is captured at acceptance, so later writes cannot disturb it.
  always_ff @(posedge clk) begin
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      pipe_addr_q[i] <= pipe_addr_q[i-1];
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
    pipe_addr_q[0] <= req_addr;
    pipe_data_q[0] <= rd_data_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
      pipe_vld_q[0] <= acc_rd_c;
      resp_valid_q  <= launch_c;
      resp_addr_q   <= pipe_addr_q[READ_LATENCY-1];
      resp_data_q   <= pipe_data_q[READ_LATENCY-1];
    end
  end

  // Init / ready / refresh sequencing; req_ready is registered from next-cycle state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      ref_tmr_q     <= '0;
      ref_cnt_q     <= '0;
      outstanding_q <= '0;
      req_ready_q   <= 1'b0;
      init_done_q   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == INIT_W'(INIT_CYCLES)) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
            ref_tmr_q   <= '0;
            req_ready_q <= ready_next_c;
          end else begin
            init_cnt_q  <= init_cnt_q + INIT_W'(1);
          end
        end
        ST_READY: begin
          if ((REFRESH_INTERVAL != 0) && (ref_tmr_q == RI_W'(REFRESH_INTERVAL - 1))) begin
            state_q     <= ST_REFRESH;
            ref_tmr_q   <= '0;
            ref_cnt_q   <= '0;
            req_ready_q <= 1'b0;
          end else begin
            ref_tmr_q   <= ref_tmr_q + RI_W'(1);
            req_ready_q <= ready_next_c;
          end
        end
        ST_REFRESH: begin
          if (ref_cnt_q == RC_W'(REFRESH_CYCLES - 1)) begin
            state_q     <= ST_READY;
            req_ready_q <= ready_next_c;
          end else begin
            ref_cnt_q   <= ref_cnt_q + RC_W'(1);
          end
        end
        default: begin
          state_q     <= ST_INIT;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign init_done  = init_done_q;
  assign resp_valid = resp_valid_q;
  assign resp_addr  = resp_addr_q;
  assign resp_data  = resp_data_q;

endmodule
